osc_phase_accum: RTL and testbench



---
 rtl/osc_phase_accum.sv | 167 ++++++++++++++++
 tb/tb_osc_phase_accum.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_phase_accum.sv
// Time-multiplexed oscillator phase accumulator.
// Each sequencer slot delivers one pitch increment. The increment is added
// into a per-(voice, oscillator) phase register, and the new phase goes to
// the waveform stage with a slot tag and a wrap flag. Key-sync (note-on)
// and oscillator-to-oscillator hard sync within a voice force the phase
// to zero.
module osc_phase_accum #(
  parameter int VOICES   = 8,
  parameter int V_OSC    = 4,
  parameter int V_WIDTH  = 3,
  parameter int O_WIDTH  = 2,
  parameter int OE_WIDTH = 1,
  parameter int E_WIDTH  = O_WIDTH + OE_WIDTH,
  parameter int PHASE_W  = 32,
  parameter int IN_LAT   = 4
) (
  input  logic                         sCLK_XVXOSC,
  input  logic                         reset,
  input  logic [V_WIDTH+E_WIDTH-1:0]   xxxx,
  input  logic [23:0]                  osc_pitch_val,
  input  logic                         note_on,
  input  logic [V_WIDTH-1:0]           cur_key_adr,
  input  logic [V_OSC-1:0]             key_sync_en,
  input  logic [V_OSC-1:0]             hard_sync_en,
  output logic [PHASE_W-1:0]           phase_out,
  output logic [V_WIDTH+O_WIDTH-1:0]   phase_slot,
  output logic                         phase_wrap,
  output logic                         phase_valid
);

  localparam int IDX_W  = V_WIDTH + E_WIDTH;
  localparam int SLOT_W = V_WIDTH + O_WIDTH;
  localparam int SLOTS  = VOICES * V_OSC;

  // Index delay line; valid bits fill with ones after reset so stale taps are ignored
  logic [IDX_W-1:0]   dly_q [IN_LAT];
  logic [IDX_W-1:0]   dly_d [IN_LAT];
  logic [IN_LAT-1:0]  vld_q, vld_d;

  // Phase store and key-sync pending flags, one per (voice, oscillator)
  logic [PHASE_W-1:0] phase_q [SLOTS];
  logic [PHASE_W-1:0] phase_d [SLOTS];
  logic [SLOTS-1:0]   pend_q, pend_d;

  // Last update's slot and wrap, used by hard sync of the next oscillator
  logic [V_WIDTH-1:0] prev_v_q, prev_v_d;
  logic [O_WIDTH-1:0] prev_o_q, prev_o_d;
  logic               prev_wrap_q, prev_wrap_d;

  logic               note_q, note_d;

  logic [PHASE_W-1:0] out_phase_q, out_phase_d;
  logic [SLOT_W-1:0]  out_slot_q, out_slot_d;
  logic               out_wrap_q, out_wrap_d;
  logic               out_valid_q, out_valid_d;

  // Tap decode and the new-phase datapath
  logic [IDX_W-1:0]    tap;
  logic [V_WIDTH-1:0]  dv;
  logic [O_WIDTH-1:0]  dox, dox_m1;
  logic [OE_WIDTH-1:0] dsub;
  logic [SLOT_W-1:0]   tap_slot;
  logic                upd;
  logic [PHASE_W:0]    sum;
  logic                key_force, hard_force, forced;
  logic [PHASE_W-1:0]  new_phase;
  logic                new_wrap;
  logic                note_rise;

  assign tap      = dly_q[IN_LAT-1];
  assign dv       = tap[IDX_W-1 -: V_WIDTH];
  assign dox      = tap[E_WIDTH-1 -: O_WIDTH];
  assign dsub     = tap[OE_WIDTH-1:0];
  assign tap_slot = tap[IDX_W-1:OE_WIDTH];
  assign dox_m1   = dox - O_WIDTH'(1);
  assign upd      = vld_q[IN_LAT-1] && (dsub == '0);

  // Shift the sequencer index along the delay line
  always_comb begin
    dly_d[0] = xxxx;
    vld_d[0] = 1'b1;
    for (int i = 1; i < IN_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
      vld_d[i] = vld_q[i-1];
    end
  end

  // Accumulate, then apply key sync / hard sync overrides
  always_comb begin
    sum        = {1'b0, phase_q[tap_slot]} + {{(PHASE_W+1-24){1'b0}}, osc_pitch_val};
    key_force  = pend_q[tap_slot];
    hard_force = (dox != '0) && hard_sync_en[dox] && prev_wrap_q &&
                 (prev_v_q == dv) && (prev_o_q == dox_m1);
    forced     = key_force || hard_force;
    new_phase  = forced ? '0 : sum[PHASE_W-1:0];
    new_wrap   = forced || sum[PHASE_W];
  end

  // Next-state for store, pend flags, hard-sync history and output registers
  always_comb begin
    note_d      = note_on;
    note_rise   = note_on && !note_q;
    phase_d     = phase_q;
    pend_d      = pend_q;
    prev_v_d    = prev_v_q;
    prev_o_d    = prev_o_q;
    prev_wrap_d = prev_wrap_q;
    out_phase_d = out_phase_q;
    out_slot_d  = out_slot_q;
    out_wrap_d  = out_wrap_q;
    out_valid_d = 1'b0;
    if (upd) begin
      phase_d[tap_slot] = new_phase;
      pend_d[tap_slot]  = 1'b0;
      prev_v_d          = dv;
      prev_o_d          = dox;
      prev_wrap_d       = new_wrap;
      out_phase_d       = new_phase;
      out_slot_d        = tap_slot;
      out_wrap_d        = new_wrap;
      out_valid_d       = 1'b1;
    end
    // A note-on edge is applied after the clear so a coincident set survives
    if (note_rise) begin
      for (int n = 0; n < V_OSC; n++) begin
        if (key_sync_en[n]) pend_d[{cur_key_adr, O_WIDTH'(n)}] = 1'b1;
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge sCLK_XVXOSC or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < IN_LAT; i++) dly_q[i] <= '0;
      for (int i = 0; i < SLOTS; i++) phase_q[i] <= '0;
      vld_q       <= '0;
      pend_q      <= '0;
      prev_v_q    <= '0;
      prev_o_q    <= '0;
      prev_wrap_q <= 1'b0;
      note_q      <= 1'b0;
      out_phase_q <= '0;
      out_slot_q  <= '0;
      out_wrap_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      dly_q       <= dly_d;
      phase_q     <= phase_d;
      vld_q       <= vld_d;
      pend_q      <= pend_d;
      prev_v_q    <= prev_v_d;
      prev_o_q    <= prev_o_d;
      prev_wrap_q <= prev_wrap_d;
      note_q      <= note_d;
      out_phase_q <= out_phase_d;
      out_slot_q  <= out_slot_d;
      out_wrap_q  <= out_wrap_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign phase_out   = out_phase_q;
  assign phase_slot  = out_slot_q;
  assign phase_wrap  = out_wrap_q;
  assign phase_valid = out_valid_q;

endmodule

// File: tb/tb_osc_phase_accum.sv
// Directed bench for osc_phase_accum: sequencer index counter, pitch table
// delayed by IN_LAT, per-slot capture of outputs, table of expected results.
module tb_osc_phase_accum;

  localparam int IN_LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  xxxx;
  logic [23:0] osc_pitch_val;
  logic        note_on;
  logic [2:0]  cur_key_adr;
  logic [3:0]  key_sync_en;
  logic [3:0]  hard_sync_en;
  logic [31:0] phase_out;
  logic [4:0]  phase_slot;
  logic        phase_wrap;
  logic        phase_valid;

  osc_phase_accum dut (
    .sCLK_XVXOSC  (clk),
    .reset        (reset),
    .xxxx         (xxxx),
    .osc_pitch_val(osc_pitch_val),
    .note_on      (note_on),
    .cur_key_adr  (cur_key_adr),
    .key_sync_en  (key_sync_en),
    .hard_sync_en (hard_sync_en),
    .phase_out    (phase_out),
    .phase_slot   (phase_slot),
    .phase_wrap   (phase_wrap),
    .phase_valid  (phase_valid)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int          cp;
    string       name;
    int          slot;
    logic [31:0] phase;
    logic        wrap;
  } vec_t;
  vec_t vecs[$];

  logic [23:0] pitch_tab [32];
  logic [5:0]  hist [4];
  logic [5:0]  idx_cnt;
  bit          gate_sub;
  int          step_no;
  logic [31:0] last_phase [32];
  logic        last_wrap [32];
  int          upd_cnt [32];
  int          valid_total;
  int          first_slots[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%08h", name, act);
    end
  endtask

  task automatic add_vec(int cp, string name, int slot, logic [31:0] ph, logic wr);
    vec_t v;
    v.cp = cp; v.name = name; v.slot = slot; v.phase = ph; v.wrap = wr;
    vecs.push_back(v);
  endtask

  task automatic check_cp(int cp);
    foreach (vecs[i]) begin
      if (vecs[i].cp == cp) begin
        check({vecs[i].name, "_phase"}, last_phase[vecs[i].slot], vecs[i].phase);
        check({vecs[i].name, "_wrap"}, 32'(last_wrap[vecs[i].slot]), 32'(vecs[i].wrap));
      end
    end
  endtask

  task automatic capture();
    if (phase_valid === 1'b1) begin
      last_phase[phase_slot] = phase_out;
      last_wrap[phase_slot]  = phase_wrap;
      upd_cnt[phase_slot]++;
      valid_total++;
      if (first_slots.size() < 32) first_slots.push_back(int'(phase_slot));
    end
  endtask

  // Drive one cycle: index now, pitch for the index issued IN_LAT cycles ago
  task automatic step();
    logic [5:0] cur;
    cur = gate_sub ? (idx_cnt | 6'd1) : idx_cnt;
    xxxx = cur;
    osc_pitch_val = pitch_tab[hist[IN_LAT-1][5:1]];
    for (int i = IN_LAT-1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = cur;
    idx_cnt = idx_cnt + 6'd1;
    @(posedge clk);
    #1;
    step_no++;
    capture();
  endtask

  task automatic run_to(int n);
    while (step_no < n) step();
  endtask

  // Called right after reset release: first valid must arrive IN_LAT+1 edges after index 0
  task automatic restart_check(string tag);
    int first;
    first = -1;
    idx_cnt = '0;
    step_no = 0;
    gate_sub = 1'b0;
    for (int i = 0; i < IN_LAT; i++) hist[i] = '0;
    for (int k = 0; k < 12 && first < 0; k++) begin
      step();
      if (phase_valid === 1'b1) first = k + 1;
    end
    check({tag, "_first_valid_latency"}, 32'(first), 32'(IN_LAT + 1));
    check({tag, "_first_phase"}, phase_out, 32'h00FF_FFFF);
    check({tag, "_first_slot"}, 32'(phase_slot), 32'd0);
    check({tag, "_first_wrap"}, 32'(phase_wrap), 32'd0);
  endtask

  initial begin
    int vc_a, vc_b, order_errs;

    // Expected per-slot results at each checkpoint (hand computed)
    add_vec(1, "f256_s0",  0, 32'hFFFF_FF00, 1'b0);
    add_vec(1, "f256_s1",  1, 32'h0000_1000, 1'b0);
    add_vec(1, "f256_s8",  8, 32'd2048,      1'b0);
    add_vec(2, "f257_s0",  0, 32'h00FF_FEFF, 1'b1);
    add_vec(2, "f257_s1_hsync", 1, 32'h0000_0000, 1'b1);
    add_vec(3, "f258_s0",  0, 32'h01FF_FEFE, 1'b0);
    add_vec(3, "f258_s1",  1, 32'h0000_0010, 1'b0);
    add_vec(4, "ks_v2o0",  8, 32'd2072,      1'b0);
    add_vec(4, "ks_v2o1",  9, 32'd2331,      1'b0);
    add_vec(4, "ks_v2o2", 10, 32'd2590,      1'b0);
    add_vec(4, "ks_v2o3", 11, 32'd2849,      1'b0);
    add_vec(4, "ks_v3o0", 12, 32'd0,         1'b1);
    add_vec(4, "ks_v3o1", 13, 32'd3367,      1'b0);
    add_vec(4, "ks_v3o2", 14, 32'd0,         1'b1);
    add_vec(4, "ks_v3o3", 15, 32'd3885,      1'b0);
    add_vec(5, "ks_next_v3o0", 12, 32'd12,   1'b0);
    add_vec(5, "ks_next_v3o1", 13, 32'd3380, 1'b0);
    add_vec(5, "ks_next_v3o2", 14, 32'd14,   1'b0);
    add_vec(6, "coin_v3o0_oldpend", 12, 32'd24, 1'b0);
    add_vec(6, "coin_v3o2",  14, 32'd0,      1'b1);
    add_vec(7, "coin_next_v3o0", 12, 32'd0,  1'b1);
    add_vec(7, "coin_next_v3o1", 13, 32'd3406, 1'b0);
    add_vec(7, "coin_next_v3o2", 14, 32'd14, 1'b0);
    add_vec(8, "gate_after_s0",  0, 32'h06FF_FEF9, 1'b0);
    add_vec(8, "gate_after_s1",  1, 32'h0000_0060, 1'b0);
    add_vec(8, "gate_after_s12", 12, 32'd12, 1'b0);
    add_vec(8, "gate_after_s14", 14, 32'd28, 1'b0);

    for (int s = 0; s < 32; s++) begin
      pitch_tab[s]  = 24'(s);
      last_phase[s] = '0;
      last_wrap[s]  = 1'b0;
      upd_cnt[s]    = 0;
    end
    pitch_tab[0] = 24'hFF_FFFF;
    pitch_tab[1] = 24'h00_0010;
    valid_total = 0;

    reset = 1'b1;
    xxxx = '0;
    osc_pitch_val = '0;
    note_on = 1'b0;
    cur_key_adr = 3'd3;
    key_sync_en = 4'b0101;
    hard_sync_en = 4'b0010;
    gate_sub = 1'b0;
    idx_cnt = '0;
    step_no = 0;
    for (int i = 0; i < IN_LAT; i++) hist[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_phase_out", phase_out, 32'd0);
    check("rst_phase_slot", 32'(phase_slot), 32'd0);
    check("rst_phase_wrap", 32'(phase_wrap), 32'd0);
    check("rst_phase_valid", 32'(phase_valid), 32'd0);

    reset = 1'b0;
    restart_check("por");

    // Accumulation, wrap and hard sync on (v0,o1)
    run_to(64*256);
    check_cp(1);
    check("cnt_s0_f256", 32'(upd_cnt[0]), 32'd256);
    check("cnt_s31_f256", 32'(upd_cnt[31]), 32'd255);
    order_errs = 0;
    for (int i = 0; i < 32; i++) begin
      if (i >= first_slots.size() || first_slots[i] != i) order_errs++;
    end
    check("slot_order_errs", 32'(order_errs), 32'd0);
    run_to(64*257);
    check_cp(2);
    run_to(64*258);
    check_cp(3);

    // Key sync: note-on edge ahead of voice 3; level held high a whole frame
    hard_sync_en = 4'b0000;
    note_on = 1'b1;
    run_to(64*259);
    check_cp(4);
    note_on = 1'b0;
    run_to(64*260);
    check_cp(5);

    // Note-on edge in the same cycle as the (3,0) tap
    run_to(64*260 + 28);
    note_on = 1'b1;
    run_to(64*261);
    check_cp(6);
    note_on = 1'b0;
    run_to(64*262);
    check_cp(7);

    // Sub-slot gating: a full frame of sub=1 indices yields no update
    gate_sub = 1'b1;
    run_to(64*262 + 5);
    vc_a = valid_total;
    run_to(64*263);
    gate_sub = 1'b0;
    run_to(64*263 + 4);
    vc_b = valid_total;
    check("gated_valid_count", 32'(vc_b - vc_a), 32'd0);
    run_to(64*264);
    check_cp(8);

    // Reset mid-run: outputs clear without a clock edge, store clears too
    run_to(64*264 + 3);
    check("pre_reset_phase", phase_out, 32'd8153);
    check("pre_reset_slot", 32'(phase_slot), 32'd31);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_phase_out", phase_out, 32'd0);
    check("midrst_phase_slot", 32'(phase_slot), 32'd0);
    check("midrst_phase_wrap", 32'(phase_wrap), 32'd0);
    check("midrst_phase_valid", 32'(phase_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    restart_check("midrst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
